bus_master_port: RTL and testbench
==================================

# bus_master_port

Bus-master front end that turns a single-word core access into the four-master shared bus protocol. A core (CPU fetch/data path, DMA, debug unit) presents one access at a time. The port then:

- requests the bus and waits for grant;
- issues a one-cycle address strobe;
- waits for the slave-side ready;
- returns read data with a one-cycle completion pulse.

A watchdog aborts accesses to non-responding slaves. One instance sits on each of the bus master ports m0..m3.

## Interface

Parameters:
- TIMEOUT, 255: ACCESS cycles without ready before abort; legal range 1..65535.
- TO_W, 8: timeout counter width; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- cpu_as_  in  1  core access strobe, active low; held low with cpu_addr/cpu_rw/cpu_wr_data stable until cpu_done
- cpu_addr  in  30  word address
- cpu_rw  in  1  1 = read, 0 = write
- cpu_wr_data  in  32  write data
- cpu_rd_data  out  32  read data, valid when cpu_done=1 and read
- cpu_done  out  1  one-cycle completion pulse
- cpu_err  out  1  qualifies cpu_done: 1 = timeout abort
- cpu_busy  out  1  1 while state != IDLE
- m_req_  out  1  bus request, active low
- m_grnt_  in  1  bus grant, active low
- m_addr  out  30  bus address
- m_as_  out  1  bus address strobe, active low
- m_rw  out  1  bus read/write
- m_wr_data  out  32  bus write data
- m_rd_data  in  32  shared read data
- m_rdy_  in  1  shared ready, active low

## Operation

- All outputs are registered.
- Reset values (reset=0 at an edge):
  - state = IDLE
  - m_req_ = 1, m_as_ = 1, m_rw = 1
  - m_addr = 0, m_wr_data = 0
  - cpu_rd_data = 0, cpu_done = 0, cpu_err = 0, cpu_busy = 0
  - counter = 0
- Reset mid-access drops m_req_/m_as_ to 1 at that edge; no completion pulse is generated.
- IDLE:
  - If cpu_as_=0 and cpu_done=0, latch addr/rw/wr_data onto m_addr/m_rw/m_wr_data, set m_req_=0 and cpu_busy=1, go to REQ.
  - cpu_as_ is ignored in the cycle cpu_done=1, which prevents re-issue of a held strobe.
- REQ:
  - Hold m_req_=0.
  - On m_grnt_=0, set m_as_=0, clear the counter, go to ACCESS.
- ACCESS:
  - m_as_ is low only for the first ACCESS cycle; it is set back to 1 at the next edge.
  - m_rdy_ is sampled at every ACCESS edge, including the strobe cycle.
  - On m_rdy_=0:
    - cpu_done=1, cpu_err=0.
    - If read, cpu_rd_data=m_rd_data; if write, cpu_rd_data is unchanged.
    - m_req_=1, cpu_busy=0, go to IDLE.
  - Otherwise the counter increments. When counter == TIMEOUT-1 and m_rdy_=1:
    - cpu_done=1, cpu_err=1, cpu_rd_data=0.
    - m_req_=1, m_as_=1, go to IDLE.
  - If ready and timeout fall on the same edge, ready wins and cpu_err=0.
  - m_grnt_ is not examined in ACCESS.
- cpu_done and cpu_err return to 0 one cycle later.
- m_addr, m_rw and m_wr_data hold their values until the next latch.

## Timing

- Grant at the first REQ edge, ready in the strobe cycle: cpu_as_ low at edge E0 gives m_req_ low after E0, m_as_ low after E1, cpu_done high after E2. Minimum latency is 3 cycles.
- Each extra grant-wait cycle or slave wait state adds exactly 1 cycle.
- Timeout: cpu_done rises after exactly TIMEOUT ACCESS cycles.
- Back-to-back accesses:
  - The next access can be latched at the edge after the cpu_done cycle.
  - m_req_ is high for at least 1 cycle between accesses, which lets the arbiter rotate.

## Test plan

- Read, immediate grant, slave ready in strobe cycle with m_rd_data=0xDEADBEEF:
  - m_req_ low 2 cycles, m_as_ low 1 cycle, m_addr=cpu_addr.
  - cpu_done one pulse 3 cycles after cpu_as_, cpu_rd_data=0xDEADBEEF, cpu_err=0.
- Write 0x12345678 to 0x0000100, grant delayed 4 cycles, 2 slave wait states:
  - m_rw=0, m_wr_data=0x12345678.
  - cpu_done at cycle 9, cpu_rd_data unchanged.
- TIMEOUT=4, slave never ready:
  - cpu_done=1, cpu_err=1, cpu_rd_data=0 after 4 ACCESS cycles.
  - m_req_=1 the same cycle.
  - Repeat with m_rdy_=0 on the 4th cycle: cpu_err=0.
- cpu_as_ held low through cpu_done and one cycle beyond:
  - Exactly one new access starts, latched at the edge after the cpu_done cycle.
  - No duplicate strobe.
- reset=0 asserted in REQ and again in ACCESS:
  - All outputs take reset values next edge.
  - No cpu_done.
  - A fresh access after release completes normally.

Source files
------------

// File: rtl/bus_master_port.sv
// bus_master_port: front end that turns one core access at a time into a
// shared-bus transaction. It requests the bus, issues a one-cycle address
// strobe, waits for slave ready and returns a one-cycle completion pulse.
// A watchdog aborts accesses to slaves that never answer.
module bus_master_port #(
    parameter int TIMEOUT = 255,  // ACCESS cycles without ready before abort
    parameter int TO_W    = 8     // watchdog width, 2**TO_W > TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_as_,
    input  logic [29:0] cpu_addr,
    input  logic        cpu_rw,
    input  logic [31:0] cpu_wr_data,
    output logic [31:0] cpu_rd_data,
    output logic        cpu_done,
    output logic        cpu_err,
    output logic        cpu_busy,
    output logic        m_req_,
    input  logic        m_grnt_,
    output logic [29:0] m_addr,
    output logic        m_as_,
    output logic        m_rw,
    output logic [31:0] m_wr_data,
    input  logic [31:0] m_rd_data,
    input  logic        m_rdy_
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // Watchdog value seen on the last ACCESS cycle before an abort.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic            m_req_q, m_req_d;
    logic            m_as_q, m_as_d;
    logic            m_rw_q, m_rw_d;
    logic [29:0]     m_addr_q, m_addr_d;
    logic [31:0]     m_wr_data_q, m_wr_data_d;
    logic [31:0]     cpu_rd_data_q, cpu_rd_data_d;
    logic            cpu_done_q, cpu_done_d;
    logic            cpu_err_q, cpu_err_d;
    logic            cpu_busy_q, cpu_busy_d;
    logic [TO_W-1:0] cnt_q, cnt_d;

    // Next-state and next-output logic for the request/strobe/ready sequence.
    always_comb begin
        // NOTE: every _d starts from its _q (or its idle value) so no branch leaves a signal unassigned and no latch is inferred.
        state_d       = state_q;
        m_req_d       = m_req_q;
        m_as_d        = m_as_q;
        m_rw_d        = m_rw_q;
        m_addr_d      = m_addr_q;
        m_wr_data_d   = m_wr_data_q;
        cpu_rd_data_d = cpu_rd_data_q;
        cpu_done_d    = 1'b0;
        cpu_err_d     = 1'b0;
        cpu_busy_d    = cpu_busy_q;
        cnt_d         = cnt_q;

        case (state_q)
            IDLE: begin
                // A strobe still held low during the completion pulse is not a new access.
                if (!cpu_as_ && !cpu_done_q) begin
                    m_addr_d    = cpu_addr;
                    m_rw_d      = cpu_rw;
                    m_wr_data_d = cpu_wr_data;
                    m_req_d     = 1'b0;
                    cpu_busy_d  = 1'b1;
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (!m_grnt_) begin
                    m_as_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // Strobe lasts exactly one cycle; grant is no longer looked at.
                m_as_d = 1'b1;
                if (!m_rdy_) begin
                    // Ready has priority over a timeout falling on the same edge.
                    cpu_done_d = 1'b1;
                    if (m_rw_q) begin
                        cpu_rd_data_d = m_rd_data;
                    end
                    m_req_d    = 1'b1;
                    cpu_busy_d = 1'b0;
                    state_d    = IDLE;
                end else if (cnt_q == TO_LAST) begin
                    cpu_done_d    = 1'b1;
                    cpu_err_d     = 1'b1;
                    cpu_rd_data_d = '0;
                    m_req_d       = 1'b1;
                    cpu_busy_d    = 1'b0;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: every register in the design is a plain flop, so all of them take a reset value here; reset is sampled on the clock edge only.
        if (!reset) begin
            state_q       <= IDLE;
            m_req_q       <= 1'b1;
            m_as_q        <= 1'b1;
            m_rw_q        <= 1'b1;
            m_addr_q      <= '0;
            m_wr_data_q   <= '0;
            cpu_rd_data_q <= '0;
            cpu_done_q    <= 1'b0;
            cpu_err_q     <= 1'b0;
            cpu_busy_q    <= 1'b0;
            cnt_q         <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
            state_q       <= state_d;
            m_req_q       <= m_req_d;
            m_as_q        <= m_as_d;
            m_rw_q        <= m_rw_d;
            m_addr_q      <= m_addr_d;
            m_wr_data_q   <= m_wr_data_d;
            cpu_rd_data_q <= cpu_rd_data_d;
            cpu_done_q    <= cpu_done_d;
            cpu_err_q     <= cpu_err_d;
            cpu_busy_q    <= cpu_busy_d;
            cnt_q         <= cnt_d;
        end
    end

    assign m_req_      = m_req_q;
    assign m_as_       = m_as_q;
    assign m_rw        = m_rw_q;
    assign m_addr      = m_addr_q;
    assign m_wr_data   = m_wr_data_q;
    assign cpu_rd_data = cpu_rd_data_q;
    assign cpu_done    = cpu_done_q;
    assign cpu_err     = cpu_err_q;
    assign cpu_busy    = cpu_busy_q;

endmodule

// File: tb/tb_bus_master_port.sv
// Testbench for bus_master_port: table of directed accesses, hand-written
// held-strobe and mid-access reset sequences, then randomized accesses
// checked against a transaction-level latency/data model.
module tb_bus_master_port;

    localparam int TIMEOUT = 4;
    localparam int TO_W    = 3;

    logic        clk;
    logic        reset;
    logic        cpu_as_;
    logic [29:0] cpu_addr;
    logic        cpu_rw;
    logic [31:0] cpu_wr_data;
    logic [31:0] cpu_rd_data;
    logic        cpu_done;
    logic        cpu_err;
    logic        cpu_busy;
    logic        m_req_;
    logic        m_grnt_;
    logic [29:0] m_addr;
    logic        m_as_;
    logic        m_rw;
    logic [31:0] m_wr_data;
    logic [31:0] m_rd_data;
    logic        m_rdy_;

    int n_checks = 0;
    int n_pass   = 0;

    // One core access plus the bus behaviour around it, and what must come back.
    typedef struct {
        logic        rw;
        logic [29:0] addr;
        logic [31:0] wdata;
        int          gd;       // cycles the arbiter holds off the grant
        int          ws;       // slave wait states (large = never ready)
        logic [31:0] rdata;
        int          exp_lat;  // cycles from strobe sampling to cpu_done, counted as in the timing rules
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t        vecs[6];
    logic [31:0] model_rd;

    bus_master_port #(
        .TIMEOUT(TIMEOUT),
        .TO_W   (TO_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_as_    (cpu_as_),
        .cpu_addr   (cpu_addr),
        .cpu_rw     (cpu_rw),
        .cpu_wr_data(cpu_wr_data),
        .cpu_rd_data(cpu_rd_data),
        .cpu_done   (cpu_done),
        .cpu_err    (cpu_err),
        .cpu_busy   (cpu_busy),
        .m_req_     (m_req_),
        .m_grnt_    (m_grnt_),
        .m_addr     (m_addr),
        .m_as_      (m_as_),
        .m_rw       (m_rw),
        .m_wr_data  (m_wr_data),
        .m_rd_data  (m_rd_data),
        .m_rdy_     (m_rdy_)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " m_req_"},      {31'd0, m_req_},   32'd1);
        check({tag, " m_as_"},       {31'd0, m_as_},    32'd1);
        check({tag, " m_rw"},        {31'd0, m_rw},     32'd1);
        check({tag, " m_addr"},      {2'd0, m_addr},    32'd0);
        check({tag, " m_wr_data"},   m_wr_data,         32'd0);
        check({tag, " cpu_rd_data"}, cpu_rd_data,       32'd0);
        check({tag, " cpu_done"},    {31'd0, cpu_done}, 32'd0);
        check({tag, " cpu_err"},     {31'd0, cpu_err},  32'd0);
        check({tag, " cpu_busy"},    {31'd0, cpu_busy}, 32'd0);
    endtask

    // Fill in expectations from the access rules: ready on access cycle ws+1
    // unless the watchdog expires first after TIMEOUT access cycles.
    task automatic model(inout vec_t v);
        int acc_cycles;
        v.exp_err  = (v.ws + 1 > TIMEOUT);
        acc_cycles = v.exp_err ? TIMEOUT : v.ws + 1;
        v.exp_lat  = 2 + v.gd + acc_cycles;
        v.exp_rd   = v.exp_err ? 32'd0 : (v.rw ? v.rdata : model_rd);
        model_rd   = v.exp_rd;
    endtask

    // Run one access with the bench acting as arbiter and slave, then check it.
    // With keep_as the core strobe stays low past completion.
    task automatic run_access(input string tag, input vec_t v, input bit keep_as);
        int          cyc, req_lo, as_lo, busy_hi, done_n, done_cyc, acc;
        logic [31:0] rd_at;
        logic        err_at;
        logic [29:0] addr_s;
        logic        rw_s;
        logic [31:0] wd_s;
        cyc = 0; req_lo = 0; as_lo = 0; busy_hi = 0; done_n = 0; done_cyc = -1; acc = 0;
        rd_at = 'x; err_at = 1'bx; addr_s = 'x; rw_s = 1'bx; wd_s = 'x;
        cpu_addr    = v.addr;
        cpu_rw      = v.rw;
        cpu_wr_data = v.wdata;
        cpu_as_     = 1'b0;
        m_grnt_     = 1'b1;
        m_rdy_      = 1'b1;
        m_rd_data   = $urandom;
        while (done_n == 0 && cyc < 100) begin
            tick();
            cyc++;
            if (!m_req_) req_lo++;
            if (!m_as_) begin
                as_lo++;
                addr_s = m_addr;
                rw_s   = m_rw;
                wd_s   = m_wr_data;
            end
            if (cpu_busy) busy_hi++;
            if (cpu_done) begin
                done_n++;
                done_cyc = cyc;
                rd_at    = cpu_rd_data;
                err_at   = cpu_err;
            end
            if (as_lo > 0 && !cpu_done) acc++;
            m_grnt_   = (!m_req_ && req_lo > v.gd) ? 1'b0 : 1'b1;
            m_rdy_    = (acc == v.ws + 1 && !cpu_done) ? 1'b0 : 1'b1;
            m_rd_data = (acc == v.ws + 1) ? v.rdata : $urandom;
        end
        m_grnt_ = 1'b1;
        m_rdy_  = 1'b1;
        check({tag, " done seen"}, done_n,   32'd1);
        check({tag, " latency"},   done_cyc, v.exp_lat);
        check({tag, " cpu_err"},   {31'd0, err_at}, {31'd0, v.exp_err});
        check({tag, " rd_data"},   rd_at,    v.exp_rd);
        check({tag, " req cycles"},  req_lo,  v.exp_lat - 1);
        check({tag, " as cycles"},   as_lo,   32'd1);
        check({tag, " busy cycles"}, busy_hi, v.exp_lat - 1);
        check({tag, " m_addr"},    {2'd0, addr_s}, {2'd0, v.addr});
        check({tag, " m_rw"},      {31'd0, rw_s},  {31'd0, v.rw});
        check({tag, " m_wr_data"}, wd_s,     v.wdata);
        if (!keep_as) cpu_as_ = 1'b1;
        tick();
        check({tag, " done drop"}, {31'd0, cpu_done}, 32'd0);
        check({tag, " err drop"},  {31'd0, cpu_err},  32'd0);
        check({tag, " req idle"},  {31'd0, m_req_},   32'd1);
        check({tag, " busy idle"}, {31'd0, cpu_busy}, 32'd0);
        check({tag, " addr hold"}, {2'd0, m_addr},    {2'd0, v.addr});
    endtask

    initial begin
        vec_t v;
        int   lo;

        // Reset state.
        reset = 1'b0; cpu_as_ = 1'b1; cpu_addr = '0; cpu_rw = 1'b1; cpu_wr_data = '0;
        m_grnt_ = 1'b1; m_rdy_ = 1'b1; m_rd_data = '0;
        repeat (3) tick();
        check_reset_vals("reset");
        reset = 1'b1;
        tick();
        model_rd = 32'd0;

        // Directed table: {rw, addr, wdata, grant delay, wait states, rdata, latency, err, rd_data}.
        vecs[0] = '{1'b1, 30'h1234567,  32'h00000000, 0, 0,   32'hDEADBEEF, 3, 1'b0, 32'hDEADBEEF};
        vecs[1] = '{1'b0, 30'h0000100,  32'h12345678, 4, 2,   32'hCAFEF00D, 9, 1'b0, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 30'h3FFFFFFF, 32'hFFFFFFFF, 0, 100, 32'h11111111, 6, 1'b1, 32'h00000000};
        vecs[3] = '{1'b1, 30'h0000ABC,  32'h00000000, 0, 3,   32'hA5A50F0F, 6, 1'b0, 32'hA5A50F0F};
        vecs[4] = '{1'b0, 30'h2AAAAAAA, 32'h55AA55AA, 1, 1,   32'h77777777, 5, 1'b0, 32'hA5A50F0F};
        vecs[5] = '{1'b0, 30'h15555555, 32'h00000000, 2, 100, 32'h22222222, 8, 1'b1, 32'h00000000};
        for (int i = 0; i < 6; i++) begin
            run_access($sformatf("vec%0d", i), vecs[i], 1'b0);
        end
        model_rd = 32'd0;

        // Strobe held through cpu_done and one cycle beyond: exactly one re-issue.
        v = '{1'b1, 30'h0000042, 32'h0, 0, 1, 32'h0BADC0DE, 4, 1'b0, 32'h0BADC0DE};
        run_access("held1", v, 1'b1);
        run_access("held2", v, 1'b0);
        lo = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (!m_req_) lo++;
        end
        check("held no third access", lo, 32'd0);

        // Reset while waiting for grant.
        cpu_addr = 30'h0000333; cpu_rw = 1'b1; cpu_wr_data = 32'h9999AAAA;
        cpu_as_ = 1'b0; m_grnt_ = 1'b1;
        tick();
        tick();
        check("rst_req in REQ", {31'd0, m_req_}, 32'd0);
        reset = 1'b0; cpu_as_ = 1'b1;
        tick();
        check_reset_vals("rst_req");
        reset = 1'b1;
        tick();
        check("rst_req no done", {31'd0, cpu_done}, 32'd0);

        // Reset during ACCESS with a slave that has not answered yet.
        cpu_as_ = 1'b0; m_grnt_ = 1'b0;
        tick();
        tick();
        check("rst_acc strobe", {31'd0, m_as_}, 32'd0);
        tick();
        check("rst_acc busy", {31'd0, cpu_busy}, 32'd1);
        reset = 1'b0; cpu_as_ = 1'b1; m_grnt_ = 1'b1;
        tick();
        check_reset_vals("rst_acc");
        reset = 1'b1;
        tick();
        check("rst_acc no done", {31'd0, cpu_done}, 32'd0);

        // Fresh access after reset completes normally.
        model_rd = 32'd0;
        v = '{1'b1, 30'h0000777, 32'h0, 1, 0, 32'h600DF00D, 0, 1'b0, 32'h0};
        model(v);
        run_access("fresh", v, 1'b0);

        // Randomized accesses against the transaction model.
        for (int i = 0; i < 24; i++) begin
            v.rw    = 1'($urandom_range(0, 1));
            v.addr  = 30'($urandom);
            v.wdata = $urandom;
            v.gd    = int'($urandom_range(0, 5));
            v.ws    = int'($urandom_range(0, 6));
            v.rdata = $urandom;
            model(v);
            run_access($sformatf("rnd%0d", i), v, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
